uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CMD_FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_CMD_BURST, default 4, consecutive commands granted while data waits.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports: CLK_I and RST_NI.
REQ-004 CLK_I  in  1  system clock.
REQ-005 RST_NI  in  1  async active-low reset.
REQ-006 CMD_VALID_I  in  1  command byte offered.
REQ-007 CMD_I  in  8  command byte (address-change notification).
REQ-008 CMD_READY_O  out  1  command accepted this cycle when high with CMD_VALID_I.
REQ-009 DATA_VALID_I  in  1  serializer data byte offered.
REQ-010 DATA_I  in  8  serializer data byte.
REQ-011 DATA_LAST_I  in  1  byte is final byte of a serialized word (frame).
REQ-012 DATA_READY_O  out  1  data byte accepted this cycle.
REQ-013 TX_READY_I  in  1  UART transmitter can take a byte.
REQ-014 TX_WRITE_O  out  1  one-cycle write strobe to UART TX.
REQ-015 TX_DATA_O  out  8  byte to transmit.
REQ-016 TX_SEND_COMMAND_O  out  1  qualifies TX_WRITE_O as command byte.
REQ-017 BUSY_O  out  1  frame in progress or commands pending.

Function
REQ-018 Commands SHALL be pushed into an internal FIFO when CMD_VALID_I && CMD_READY_O; CMD_READY_O = FIFO not full, from registered count only.
REQ-019 A grant cycle SHALL require TX_READY_I=1 and holdoff=0; holdoff SHALL be 1 in the cycle after any grant, limiting grants to every other cycle.
REQ-020 Granted byte SHALL appear at next cycle: TX_WRITE_O=1 for one cycle, TX_DATA_O=byte, TX_SEND_COMMAND_O=1 iff byte came from FIFO; outside strobes TX_WRITE_O=0, TX_SEND_COMMAND_O=0, TX_DATA_O holds.
REQ-021 FSM states IDLE and FRAME.
REQ-022 IDLE: if FIFO non-empty and (cmd_burst<MAX_CMD_BURST or !DATA_VALID_I), grant FIFO head (pop) and increment cmd_burst (saturating).
REQ-023 IDLE otherwise: if DATA_VALID_I, grant data (DATA_READY_O=1 combinationally), clear cmd_burst; go FRAME iff DATA_LAST_I=0.
REQ-024 FRAME: only data granted; commands queue; on granted byte with DATA_LAST_I=1 return to IDLE; no command byte SHALL ever be interleaved inside a frame.
REQ-025 DATA_READY_O SHALL be high only in a data-grant cycle; FIFO pop only in a command-grant cycle; never both.
REQ-026 Push into empty FIFO SHALL be grantable no earlier than next cycle (min latency CMD_VALID_I to TX_WRITE_O = 2 cycles).
REQ-027 Push and pop in same cycle SHALL keep count unchanged; full FIFO SHALL hold CMD_READY_O=0 until a pop, no overwrite.
REQ-028 FIFO pointers SHALL wrap modulo CMD_FIFO_DEPTH; count width clog2(CMD_FIFO_DEPTH+1).
REQ-029 TX_READY_I low SHALL stall grants without losing state; DATA_VALID_I drop mid-frame SHALL keep FRAME.
REQ-030 BUSY_O = (state==FRAME) || FIFO non-empty || TX_WRITE_O.

Reset
REQ-031 RST_NI low SHALL immediately clear: state IDLE, FIFO empty, cmd_burst 0, holdoff 0, TX_WRITE_O 0, TX_SEND_COMMAND_O 0, TX_DATA_O 0x00, BUSY_O 0; CMD_READY_O 1 and DATA_READY_O 0 from first cycle after release.
REQ-032 Reset mid-frame or with pending commands SHALL discard them; no TX_WRITE_O SHALL follow release without a new request.

Structure
REQ-033 State enum (ARB_IDLE, ARB_FRAME) and default CMD_FIFO_DEPTH/MAX_CMD_BURST constants SHALL live in uart_pkg.
REQ-034 Command FIFO SHALL be sub-module tx_cmd_fifo (8-bit, parameterized depth, full/empty/count).

Verification
REQ-035 Single command 0x05, TX_READY_I=1 -> TX_WRITE_O at cycle+2, TX_DATA_O=0x05, TX_SEND_COMMAND_O=1.
REQ-036 4-byte frame 0xA1..0xA4 with command 0x11 pushed after byte 1 -> TX order A1,A2,A3,A4,11; strobes 2 cycles apart.
REQ-037 Push 5 commands with TX_READY_I=0, depth 4 -> CMD_READY_O=0 on 5th; release -> 4 bytes in order.
REQ-038 6 commands queued plus DATA_VALID_I single-byte frame 0x3C -> 4 commands, 0x3C, remaining 2 commands.
REQ-039 Assert RST_NI low mid-frame with 2 queued commands -> outputs zero immediately; after release no strobe, CMD_READY_O=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART TX arbiter slice.
package uart_pkg;

    localparam int unsigned CMD_FIFO_DEPTH_DEF = 4;
    localparam int unsigned MAX_CMD_BURST_DEF  = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_FRAME = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_CMD  = 2'd1,
        GRANT_DATA = 2'd2
    } grant_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between command/serializer sources, the arbiter and the UART TX.
interface uart_tx_arbiter_if;

    logic       CMD_VALID_I;
    logic [7:0] CMD_I;
    logic       CMD_READY_O;
    logic       DATA_VALID_I;
    logic [7:0] DATA_I;
    logic       DATA_LAST_I;
    logic       DATA_READY_O;
    logic       TX_READY_I;
    logic       TX_WRITE_O;
    logic [7:0] TX_DATA_O;
    logic       TX_SEND_COMMAND_O;
    logic       BUSY_O;

    modport master (
        output CMD_VALID_I, CMD_I, DATA_VALID_I, DATA_I, DATA_LAST_I, TX_READY_I,
        input  CMD_READY_O, DATA_READY_O, TX_WRITE_O, TX_DATA_O, TX_SEND_COMMAND_O, BUSY_O
    );

    modport slave (
        input  CMD_VALID_I, CMD_I, DATA_VALID_I, DATA_I, DATA_LAST_I, TX_READY_I,
        output CMD_READY_O, DATA_READY_O, TX_WRITE_O, TX_DATA_O, TX_SEND_COMMAND_O, BUSY_O
    );

endinterface

// File: rtl/tx_cmd_fifo.sv
// Byte-wide command FIFO; DEPTH must be a power of two so pointers wrap for free.
module tx_cmd_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK_I) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX between queued command bytes and serializer frames.
// Frames are never split by commands; commands may burst ahead of waiting data
// up to MAX_CMD_BURST grants. Grants are spaced at least two cycles apart.
//
// state     | meaning
// ARB_IDLE  | between frames: commands or the first byte of a frame may win
// ARB_FRAME | frame started: only serializer bytes are granted until the last
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned CMD_FIFO_DEPTH = CMD_FIFO_DEPTH_DEF,
    parameter int unsigned MAX_CMD_BURST  = MAX_CMD_BURST_DEF
) (
    input logic               CLK_I,
    input logic               RST_NI,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W   = $clog2(CMD_FIFO_DEPTH + 1);
    localparam int unsigned BURST_W = $clog2(MAX_CMD_BURST + 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    grant_t             grant;
    logic               fifo_push;
    logic               fifo_pop;
    logic [7:0]         fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [BURST_W-1:0] cmd_burst;
    logic               holdoff;
    logic               tx_write;
    logic [7:0]         tx_data;
    logic               tx_cmd;

    tx_cmd_fifo #(.DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
        .CLK_I     (CLK_I),
        .RST_NI    (RST_NI),
        .push      (fifo_push),
        .push_data (bus.CMD_I),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) state <= ARB_IDLE;
        else         state <= state_nxt;
    end

    // Next state: only a granted data byte moves the FSM; its LAST flag decides where.
    always_comb begin
        state_nxt = state;
        if (grant == GRANT_DATA) begin
            state_nxt = bus.DATA_LAST_I ? ARB_IDLE : ARB_FRAME;
        end
    end

    // Grant decision; the FIFO's empty flag is registered, so a fresh push waits a cycle.
    always_comb begin
        grant = GRANT_NONE;
        if (bus.TX_READY_I && !holdoff) begin
            unique case (state)
                ARB_IDLE: begin
                    if (!fifo_empty &&
                        (cmd_burst < BURST_W'(MAX_CMD_BURST) || !bus.DATA_VALID_I)) begin
                        grant = GRANT_CMD;
                    end else if (bus.DATA_VALID_I) begin
                        grant = GRANT_DATA;
                    end
                end
                ARB_FRAME: begin
                    if (bus.DATA_VALID_I) grant = GRANT_DATA;
                end
                default: grant = GRANT_NONE;
            endcase
        end
    end

    assign fifo_push             = bus.CMD_VALID_I && !fifo_full;
    assign fifo_pop              = (grant == GRANT_CMD);
    assign bus.CMD_READY_O       = !fifo_full;
    assign bus.DATA_READY_O      = (grant == GRANT_DATA);
    assign bus.TX_WRITE_O        = tx_write;
    assign bus.TX_DATA_O         = tx_data;
    assign bus.TX_SEND_COMMAND_O = tx_cmd;
    assign bus.BUSY_O            = (state == ARB_FRAME) || (fifo_count != '0) || tx_write;

    // Registered TX strobe, burst counter and the one-cycle holdoff after every grant.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            holdoff   <= 1'b0;
            cmd_burst <= '0;
            tx_write  <= 1'b0;
            tx_data   <= 8'h00;
            tx_cmd    <= 1'b0;
        end else begin
            holdoff  <= (grant != GRANT_NONE);
            tx_write <= (grant != GRANT_NONE);
            tx_cmd   <= (grant == GRANT_CMD);
            if (grant == GRANT_CMD) begin
                tx_data <= fifo_head;
                if (cmd_burst != BURST_W'(MAX_CMD_BURST)) cmd_burst <= cmd_burst + 1'b1;
            end else if (grant == GRANT_DATA) begin
                tx_data   <= bus.DATA_I;
                cmd_burst <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: scenarios queue their expected TX bytes,
// a negedge monitor pops and compares on every TX_WRITE_O strobe.
module tb_uart_tx_arbiter;

    logic CLK_I  = 1'b0;
    logic RST_NI = 1'b0;

    always #5 CLK_I = ~CLK_I;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.CMD_FIFO_DEPTH(4), .MAX_CMD_BURST(4)) dut (
        .CLK_I  (CLK_I),
        .RST_NI (RST_NI),
        .bus    (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         last_strobe = -1;
    logic [8:0] exp_q[$];
    int         strobe_cyc[$];

    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge CLK_I) begin
        if (!RST_NI) begin
            last_strobe = -1;
        end else if (bus.TX_WRITE_O === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got cmd=%0b data=0x%0h expected no strobe (cycle %0d)",
                         bus.TX_SEND_COMMAND_O, bus.TX_DATA_O, cyc);
            end else begin
                check("tx_byte", {23'd0, bus.TX_SEND_COMMAND_O, bus.TX_DATA_O}, {23'd0, exp_q.pop_front()});
            end
            if (last_strobe >= 0) check("strobe_gap_ge2", 32'(cyc - last_strobe >= 2), 32'd1);
            last_strobe = cyc;
            strobe_cyc.push_back(cyc);
        end
    end

    task automatic idle_inputs();
        bus.CMD_VALID_I  = 1'b0;
        bus.CMD_I        = 8'h00;
        bus.DATA_VALID_I = 1'b0;
        bus.DATA_I       = 8'h00;
        bus.DATA_LAST_I  = 1'b0;
        bus.TX_READY_I   = 1'b0;
    endtask

    // Called and returns at a negedge.
    task automatic do_reset();
        RST_NI = 1'b0;
        idle_inputs();
        exp_q.delete();
        repeat (2) @(negedge CLK_I);
        RST_NI = 1'b1;
    endtask

    task automatic push_cmd(input logic [7:0] b);
        logic ok = 1'b0;
        bus.CMD_VALID_I = 1'b1;
        bus.CMD_I       = b;
        for (int n = 0; n < 100; n++) begin
            #1 ok = bus.CMD_READY_O;
            @(posedge CLK_I);
            if (ok) break;
            @(negedge CLK_I);
        end
        if (ok) @(negedge CLK_I);
        else begin
            total++; bad++;
            $display("FAIL cmd_push_timeout: got no CMD_READY_O expected accept of 0x%0h", b);
        end
        bus.CMD_VALID_I = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input logic last);
        logic ok = 1'b0;
        bus.DATA_VALID_I = 1'b1;
        bus.DATA_I       = b;
        bus.DATA_LAST_I  = last;
        for (int n = 0; n < 100; n++) begin
            #1 ok = bus.DATA_READY_O;
            @(posedge CLK_I);
            if (ok) break;
            @(negedge CLK_I);
        end
        if (ok) @(negedge CLK_I);
        else begin
            total++; bad++;
            $display("FAIL data_timeout: got no DATA_READY_O expected accept of 0x%0h", b);
        end
        bus.DATA_VALID_I = 1'b0;
        bus.DATA_LAST_I  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK_I);
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (6) @(negedge CLK_I);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        idle_inputs();
        repeat (3) @(negedge CLK_I);
        RST_NI = 1'b1;

        check("rst_cmd_ready",  bus.CMD_READY_O,       1);
        check("rst_data_ready", bus.DATA_READY_O,      0);
        check("rst_tx_write",   bus.TX_WRITE_O,        0);
        check("rst_send_cmd",   bus.TX_SEND_COMMAND_O, 0);
        check("rst_tx_data",    bus.TX_DATA_O,         0);
        check("rst_busy",       bus.BUSY_O,            0);

        // Single command: strobe two cycles after the push cycle.
        bus.TX_READY_I = 1'b1;
        exp_q.push_back({1'b1, 8'h05});
        push_cmd(8'h05);
        check("t1_no_early_strobe", bus.TX_WRITE_O, 0);
        check("t1_busy_pending",    bus.BUSY_O,     1);
        @(negedge CLK_I);
        check("t1_strobe_latency",  bus.TX_WRITE_O, 1);
        wait_drain("t1_drained", 20);

        // Frame A1..A4 with command queued after A1: command waits for frame end.
        do_reset();
        bus.TX_READY_I = 1'b1;
        n0 = strobe_cyc.size();
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hA2});
        exp_q.push_back({1'b0, 8'hA3});
        exp_q.push_back({1'b0, 8'hA4});
        exp_q.push_back({1'b1, 8'h11});
        send_data(8'hA1, 1'b0);
        fork
            push_cmd(8'h11);
            begin
                send_data(8'hA2, 1'b0);
                send_data(8'hA3, 1'b0);
                send_data(8'hA4, 1'b1);
            end
        join
        wait_drain("t2_drained", 40);
        check("t2_strobe_count", strobe_cyc.size() - n0, 5);
        if (strobe_cyc.size() >= n0 + 5) begin
            for (int i = n0 + 1; i < n0 + 5; i++)
                check("t2_gap_eq2", strobe_cyc[i] - strobe_cyc[i-1], 2);
        end

        // FIFO full with TX stalled: 5th command refused, then 4 drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b1, 8'(8'h41 + i)});
            push_cmd(8'(8'h41 + i));
        end
        bus.CMD_VALID_I = 1'b1;
        bus.CMD_I       = 8'h45;
        for (int i = 0; i < 3; i++) begin
            #1 check("t3_full_not_ready", bus.CMD_READY_O, 0);
            @(negedge CLK_I);
        end
        bus.CMD_VALID_I = 1'b0;
        check("t3_stall_no_write", bus.TX_WRITE_O, 0);
        check("t3_busy",           bus.BUSY_O,     1);
        bus.TX_READY_I = 1'b1;
        wait_drain("t3_drained", 40);

        // Six commands vs single-byte frame: burst of 4, then data, then the rest.
        do_reset();
        for (int i = 0; i < 4; i++) push_cmd(8'(8'h61 + i));
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'(8'h61 + i)});
        exp_q.push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b1, 8'h65});
        exp_q.push_back({1'b1, 8'h66});
        fork
            begin
                bus.TX_READY_I = 1'b1;
                send_data(8'h3C, 1'b1);
            end
            begin
                push_cmd(8'h65);
                push_cmd(8'h66);
            end
        join
        wait_drain("t4_drained", 60);

        // Data gap and TX stall inside a frame: FRAME holds, command waits.
        do_reset();
        bus.TX_READY_I = 1'b1;
        exp_q.push_back({1'b0, 8'hD1});
        exp_q.push_back({1'b0, 8'hD2});
        exp_q.push_back({1'b1, 8'h77});
        send_data(8'hD1, 1'b0);
        repeat (2) @(negedge CLK_I);
        check("t5_busy_in_frame", bus.BUSY_O,       1);
        check("t5_no_data_ready", bus.DATA_READY_O, 0);
        push_cmd(8'h77);
        for (int i = 0; i < 3; i++) begin
            check("t5_no_cmd_in_frame", bus.TX_WRITE_O, 0);
            @(negedge CLK_I);
        end
        bus.TX_READY_I = 1'b0;
        fork
            send_data(8'hD2, 1'b1);
            begin
                repeat (4) @(negedge CLK_I);
                check("t5_stalled", bus.TX_WRITE_O, 0);
                bus.TX_READY_I = 1'b1;
            end
        join
        wait_drain("t5_drained", 40);

        // Reset mid-frame with two queued commands: everything discarded.
        do_reset();
        bus.TX_READY_I = 1'b1;
        exp_q.push_back({1'b0, 8'hB1});
        send_data(8'hB1, 1'b0);
        push_cmd(8'h21);
        push_cmd(8'h22);
        wait_drain("t6_first_byte", 20);
        check("t6_busy_before", bus.BUSY_O, 1);
        #2 RST_NI = 1'b0;
        #1;
        check("t6_rst_tx_write", bus.TX_WRITE_O,        0);
        check("t6_rst_send_cmd", bus.TX_SEND_COMMAND_O, 0);
        check("t6_rst_tx_data",  bus.TX_DATA_O,         0);
        check("t6_rst_busy",     bus.BUSY_O,            0);
        @(negedge CLK_I);
        RST_NI = 1'b1;
        repeat (10) @(negedge CLK_I);
        check("t6_cmd_ready",  bus.CMD_READY_O,  1);
        check("t6_data_ready", bus.DATA_READY_O, 0);
        check("t6_busy_after", bus.BUSY_O,       0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
